// File: rtl/apu_pkg.sv
// Shared APU definitions: wave mode encoding, NES length-counter table and
// the wave shape function used by the wavetable channel.
package apu_pkg;

  typedef enum logic [1:0] {
    TRI    = 2'd0,
    SAW_UP = 2'd1,
    SAW_DN = 2'd2,
    HOLD   = 2'd3
  } wave_mode_t;

  localparam int LEN_W   = 8;
  localparam int SHAPE_W = 16;

  localparam logic [LEN_W-1:0] LENGTH_TABLE [32] = '{
    8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
  };

  // n = index width, amp_w = sample width; both are elaboration constants.
  function automatic logic [SHAPE_W-1:0] wave_shape(
    input wave_mode_t         mode,
    input logic [SHAPE_W-1:0] idx,
    input int                 n,
    input int                 amp_w
  );
    logic [SHAPE_W-1:0] mask_n;
    logic [SHAPE_W-1:0] mask_h;
    logic [SHAPE_W-1:0] mask_a;
    logic [SHAPE_W-1:0] f;
    logic [SHAPE_W-1:0] r;
    mask_n = SHAPE_W'((32'd1 << n) - 32'd1);
    mask_h = SHAPE_W'((32'd1 << (n - 1)) - 32'd1);
    mask_a = SHAPE_W'((32'd1 << amp_w) - 32'd1);
    f      = idx & mask_n;
    case (mode)
      SAW_UP:  r = f >> (n - amp_w);
      SAW_DN:  r = (~f & mask_n) >> (n - amp_w);
      default: begin
        r = (idx[n-1] ? f : ~f) & mask_h;
        r = r >> (n - 1 - amp_w);
      end
    endcase
    return r & mask_a;
  endfunction

endpackage

// File: rtl/apu_length_counter.sv
// APU length counter: table load, halt and disable handling; shared by the
// pulse, noise and wavetable channels.
module apu_length_counter
  import apu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_l,
  input  logic       tick_en,
  input  logic       halt,
  input  logic       enable,
  input  logic       load,
  input  logic [4:0] load_idx,
  output logic       non_zero
);

  logic [LEN_W-1:0] r_count;

  // Disable dominates everything, and a load beats a coincident tick.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_count <= '0;
    end else if (!enable) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= LENGTH_TABLE[load_idx];
    end else if (tick_en && !halt && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign non_zero = (r_count != '0);

endmodule

// File: rtl/wavetable_channel.sv
// Wavetable channel: timer-driven step sequencer gated by linear and length
// counters. Optional build macro: ULTRASONIC_MUTE_EN (freeze sequencer when period < 2).
module wavetable_channel
  import apu_pkg::*;
#(
  parameter int TIMER_W  = 11,
  parameter int SEQ_LOG2 = 5,
  parameter int AMP_W    = 4,
  parameter int LIN_W    = 7
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic                cpu_clk_en,
  input  logic                counter_clk_en,
  input  logic                disable_l,
  input  logic                control_flag,
  input  logic [1:0]          mode,
  input  logic                phase_reset,
  input  logic                linear_load,
  input  logic                timer_load,
  input  logic                length_load,
  input  logic [LIN_W-1:0]    linear_load_data,
  input  logic [TIMER_W-1:0]  timer_load_data,
  input  logic [4:0]          length_load_data,
  output logic                linear_non_zero,
  output logic                length_non_zero,
  output logic [SEQ_LOG2-1:0] step,
  output logic [AMP_W-1:0]    wave
);

  if (AMP_W < 1 || AMP_W > SEQ_LOG2 - 1 || SEQ_LOG2 > SHAPE_W) begin : g_param_check
    $error("wavetable_channel: need 1 <= AMP_W <= SEQ_LOG2-1 and SEQ_LOG2 <= 16");
  end

  logic [TIMER_W-1:0]  r_period;
  logic [TIMER_W-1:0]  r_count;
  logic [SEQ_LOG2-1:0] r_index;
  logic [LIN_W-1:0]    r_linear;
  logic [LIN_W-1:0]    r_lin_reload;
  logic                r_reload_flag;

  wave_mode_t          w_mode;
  logic                w_timer_pulse;
  logic                w_period_ok;
  logic                w_step_en;
  logic                w_length_nz;
  logic [LIN_W-1:0]    w_lin_reload_src;

  assign w_mode        = wave_mode_t'(mode);
  assign w_timer_pulse = cpu_clk_en && (r_count == '0);

`ifdef ULTRASONIC_MUTE_EN
  assign w_period_ok = (r_period > TIMER_W'(1));
`else
  assign w_period_ok = 1'b1;
`endif

  assign w_step_en = w_timer_pulse && linear_non_zero && w_length_nz &&
                     (w_mode != HOLD) && w_period_ok;

  // Period writes are buffered: only a reload or phase reset moves them into the count.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_period <= '0;
      r_count  <= '0;
      r_index  <= '0;
    end else begin
      if (timer_load) r_period <= timer_load_data;
      if (phase_reset) begin
        r_count <= r_period;
        r_index <= '0;
      end else begin
        if (cpu_clk_en) r_count <= w_timer_pulse ? r_period : r_count - 1'b1;
        if (w_step_en)  r_index <= r_index + 1'b1;
      end
    end
  end

  // A reload write coinciding with a tick is visible to that tick's reload.
  assign w_lin_reload_src = linear_load ? linear_load_data : r_lin_reload;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_linear      <= '0;
      r_lin_reload  <= '0;
      r_reload_flag <= 1'b0;
    end else begin
      if (linear_load) r_lin_reload <= linear_load_data;
      if (counter_clk_en) begin
        if (r_reload_flag)       r_linear <= w_lin_reload_src;
        else if (r_linear != '0) r_linear <= r_linear - 1'b1;
      end
      if (linear_load)                         r_reload_flag <= 1'b1;
      else if (counter_clk_en && !control_flag) r_reload_flag <= 1'b0;
    end
  end

  apu_length_counter u_length (
    .clk      (clk),
    .rst_l    (rst_l),
    .tick_en  (counter_clk_en),
    .halt     (control_flag),
    .enable   (disable_l),
    .load     (length_load),
    .load_idx (length_load_data),
    .non_zero (w_length_nz)
  );

  assign linear_non_zero = (r_linear != '0);
  assign length_non_zero = w_length_nz;
  assign step            = r_index;
  assign wave            = AMP_W'(wave_shape(w_mode, SHAPE_W'(r_index), SEQ_LOG2, AMP_W));

endmodule

// File: tb/tb_wavetable_channel.sv
// Self-checking bench for wavetable_channel: directed scenarios plus random
// traffic, all compared against a cycle-level behavioural model.
module tb_wavetable_channel;

  localparam int TIMER_W  = 11;
  localparam int SEQ_LOG2 = 5;
  localparam int AMP_W    = 4;
  localparam int LIN_W    = 7;

  logic                clk = 1'b0;
  logic                rst_l = 1'b0;
  logic                cpu_clk_en = 1'b0;
  logic                counter_clk_en = 1'b0;
  logic                disable_l = 1'b1;
  logic                control_flag = 1'b0;
  logic [1:0]          mode = 2'd0;
  logic                phase_reset = 1'b0;
  logic                linear_load = 1'b0;
  logic                timer_load = 1'b0;
  logic                length_load = 1'b0;
  logic [LIN_W-1:0]    linear_load_data = '0;
  logic [TIMER_W-1:0]  timer_load_data = '0;
  logic [4:0]          length_load_data = '0;
  logic                linear_non_zero;
  logic                length_non_zero;
  logic [SEQ_LOG2-1:0] step;
  logic [AMP_W-1:0]    wave;

  wavetable_channel #(
    .TIMER_W  (TIMER_W),
    .SEQ_LOG2 (SEQ_LOG2),
    .AMP_W    (AMP_W),
    .LIN_W    (LIN_W)
  ) dut (
    .clk              (clk),
    .rst_l            (rst_l),
    .cpu_clk_en       (cpu_clk_en),
    .counter_clk_en   (counter_clk_en),
    .disable_l        (disable_l),
    .control_flag     (control_flag),
    .mode             (mode),
    .phase_reset      (phase_reset),
    .linear_load      (linear_load),
    .timer_load       (timer_load),
    .length_load      (length_load),
    .linear_load_data (linear_load_data),
    .timer_load_data  (timer_load_data),
    .length_load_data (length_load_data),
    .linear_non_zero  (linear_non_zero),
    .length_non_zero  (length_non_zero),
    .step             (step),
    .wave             (wave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int len_tab [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                       12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};
  int tri_seq [32] = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0,
                       0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
  int saw_up_seq [4] = '{0, 0, 1, 1};
  int saw_dn_seq [4] = '{15, 15, 14, 14};

  int m_period, m_count, m_index, m_linear, m_reload, m_flag, m_length;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_wave(input int md, input int i);
    int half;
    int f;
    half = 1 << (SEQ_LOG2 - 1);
    if (md == 1) return i >> (SEQ_LOG2 - AMP_W);
    if (md == 2) return ((1 << SEQ_LOG2) - 1 - i) >> (SEQ_LOG2 - AMP_W);
    f = (i >= half) ? i - half : half - 1 - i;
    return f >> (SEQ_LOG2 - 1 - AMP_W);
  endfunction

  task automatic model_reset();
    m_period = 0; m_count = 0; m_index = 0;
    m_linear = 0; m_reload = 0; m_flag = 0; m_length = 0;
  endtask

  // One clock edge of the channel, evaluated from the behaviour rules.
  task automatic model_clock();
    bit pulse, adv, period_ok;
    int n_count, n_index, n_linear, n_flag, n_length, n_reload;
    pulse = cpu_clk_en && (m_count == 0);
`ifdef ULTRASONIC_MUTE_EN
    period_ok = (m_period >= 2);
`else
    period_ok = 1'b1;
`endif
    adv = pulse && (m_linear != 0) && (m_length != 0) && (mode != 2'd3) && period_ok;
    n_count = m_count;
    n_index = m_index;
    if (phase_reset) begin
      n_count = m_period;
      n_index = 0;
    end else begin
      if (cpu_clk_en) n_count = (m_count == 0) ? m_period : m_count - 1;
      if (adv) n_index = (m_index + 1) % (1 << SEQ_LOG2);
    end
    n_reload = linear_load ? int'(linear_load_data) : m_reload;
    n_linear = m_linear;
    if (counter_clk_en) begin
      if (m_flag != 0) n_linear = n_reload;
      else if (m_linear > 0) n_linear = m_linear - 1;
    end
    n_flag = m_flag;
    if (linear_load) n_flag = 1;
    else if (counter_clk_en && !control_flag) n_flag = 0;
    n_length = m_length;
    if (!disable_l) n_length = 0;
    else if (length_load) n_length = len_tab[length_load_data];
    else if (counter_clk_en && !control_flag && m_length > 0) n_length = m_length - 1;
    if (timer_load) m_period = int'(timer_load_data);
    m_count = n_count; m_index = n_index; m_reload = n_reload;
    m_linear = n_linear; m_flag = n_flag; m_length = n_length;
  endtask

  task automatic compare_all();
    check_eq("step", int'(step), m_index);
    check_eq("wave", int'(wave), exp_wave(int'(mode), m_index));
    check_eq("linear_non_zero", int'(linear_non_zero), int'(m_linear != 0));
    check_eq("length_non_zero", int'(length_non_zero), int'(m_length != 0));
  endtask

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      model_clock();
      #1;
      compare_all();
    end
  endtask

  task automatic clear_strobes();
    counter_clk_en = 1'b0; phase_reset = 1'b0; linear_load = 1'b0;
    timer_load = 1'b0; length_load = 1'b0;
  endtask

  // Program period, linear and length with the timer idle, then phase-reset.
  task automatic setup_channel(input int period, input int lin, input int len_idx, input int md);
    cpu_clk_en = 1'b0; control_flag = 1'b1; disable_l = 1'b1; mode = 2'(md);
    clear_strobes();
    timer_load = 1'b1; timer_load_data = TIMER_W'(period); cycle(1); timer_load = 1'b0;
    linear_load = 1'b1; linear_load_data = LIN_W'(lin); cycle(1); linear_load = 1'b0;
    counter_clk_en = 1'b1; cycle(1); counter_clk_en = 1'b0;
    length_load = 1'b1; length_load_data = 5'(len_idx); cycle(1); length_load = 1'b0;
    phase_reset = 1'b1; cycle(1); phase_reset = 1'b0;
  endtask

  task automatic counter_tick();
    counter_clk_en = 1'b1; cycle(1); counter_clk_en = 1'b0; cycle(1);
  endtask

  initial begin
    int frozen;
    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_step", int'(step), 0);
    check_eq("rst_wave", int'(wave), 15);
    check_eq("rst_lin_nz", int'(linear_non_zero), 0);
    check_eq("rst_len_nz", int'(length_non_zero), 0);
    rst_l = 1'b1;

    // Gated stepping in TRI: one step per 4 ticks, full sequence and wrap
    setup_channel(3, 5, 1, 0);
    check_eq("tri_start", int'(wave), 15);
    cpu_clk_en = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      cycle(4);
      check_eq("tri_seq", int'(wave), tri_seq[k % 32]);
      check_eq("tri_step", int'(step), k % 32);
    end

    // Linear counter runs out and freezes the sequencer
    control_flag = 1'b0;
    linear_load = 1'b1; linear_load_data = LIN_W'(2); cycle(1); linear_load = 1'b0;
    counter_tick(); counter_tick();
    check_eq("lin_after_2", int'(linear_non_zero), 1);
    counter_tick();
    check_eq("lin_zero", int'(linear_non_zero), 0);
    frozen = m_index;
    cycle(12);
    check_eq("freeze_step", int'(step), frozen);

    // Length counter load, decrement and disable
    cpu_clk_en = 1'b0;
    length_load = 1'b1; length_load_data = 5'd3; cycle(1); length_load = 1'b0;
    check_eq("len_loaded", int'(length_non_zero), 1);
    counter_tick(); counter_tick();
    check_eq("len_expired", int'(length_non_zero), 0);
    length_load = 1'b1; length_load_data = 5'd1; cycle(1); length_load = 1'b0;
    disable_l = 1'b0; cycle(1);
    check_eq("len_disabled", int'(length_non_zero), 0);
    length_load = 1'b1; cycle(1); length_load = 1'b0;
    check_eq("len_load_ignored", int'(length_non_zero), 0);
    disable_l = 1'b1;

    // Saw shapes from step 0
    setup_channel(3, 5, 1, 1);
    cpu_clk_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_eq("saw_up", int'(wave), saw_up_seq[k]);
      cycle(4);
    end
    setup_channel(3, 5, 1, 2);
    cpu_clk_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_eq("saw_dn", int'(wave), saw_dn_seq[k]);
      cycle(4);
    end

    // Phase reset coincident with a timer pulse wins over the step
    setup_channel(3, 5, 1, 0);
    cpu_clk_en = 1'b1;
    cycle(8);
    cycle(3);
    phase_reset = 1'b1; cycle(1); phase_reset = 1'b0;
    check_eq("phase_rst_step", int'(step), 0);
    cycle(4);
    check_eq("phase_rst_next", int'(step), 1);

    // Period buffering: new period waits for a reload, then 8-tick spacing
    cycle(1);
    timer_load = 1'b1; timer_load_data = TIMER_W'(7); cycle(1); timer_load = 1'b0;
    cycle(20);
    phase_reset = 1'b1; cycle(1); phase_reset = 1'b0;
    cycle(7);
    check_eq("p7_before", int'(step), 0);
    cycle(1);
    check_eq("p7_step", int'(step), 1);

    // Asynchronous reset mid-cycle
    cycle(5);
    mode = 2'd0;
    #3 rst_l = 1'b0;
    #1;
    model_reset();
    check_eq("arst_step", int'(step), 0);
    check_eq("arst_wave", int'(wave), 15);
    check_eq("arst_lin_nz", int'(linear_non_zero), 0);
    check_eq("arst_len_nz", int'(length_non_zero), 0);
    #1 rst_l = 1'b1;

    // Very short period
    setup_channel(1, 5, 1, 0);
    cpu_clk_en = 1'b1;
    cycle(10);
`ifdef ULTRASONIC_MUTE_EN
    check_eq("ultra_step", int'(step), 0);
`else
    check_eq("ultra_step", int'(step), 5);
`endif

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      cpu_clk_en       = ($urandom_range(0, 3) != 0);
      counter_clk_en   = ($urandom_range(0, 15) == 0);
      disable_l        = ($urandom_range(0, 63) != 0);
      control_flag     = ($urandom_range(0, 3) == 0);
      mode             = 2'($urandom_range(0, 3));
      phase_reset      = ($urandom_range(0, 63) == 0);
      linear_load      = ($urandom_range(0, 31) == 0);
      timer_load       = ($urandom_range(0, 31) == 0);
      length_load      = ($urandom_range(0, 31) == 0);
      linear_load_data = LIN_W'($urandom_range(0, 127));
      timer_load_data  = TIMER_W'($urandom_range(0, 9));
      length_load_data = 5'($urandom_range(0, 31));
      cycle(1);
    end
    clear_strobes();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
